// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives ALUOp/COUNTER to the logic unit for req_last+1 phases,
// then captures result/branch/overflow. Define ALU_SEQ_ABORT_EN to add the abort input.
module alu_op_sequencer #(
  parameter int               DATA_W  = 32,
  parameter int               OP_W    = 4,
  parameter int               CNT_W   = 2,
  parameter logic [OP_W-1:0]  IDLE_OP = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   req_op,
  input  logic [CNT_W-1:0]  req_last,
  input  logic [1:0]        req_kind,
  output logic [OP_W-1:0]   ALUOp,
  output logic [CNT_W-1:0]  COUNTER,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              OVERFLOW,
  input  logic              Update_UC,
`ifdef ALU_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken,
  output logic              ovf_exc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_OVF    = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              abort_w;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [1:0]        kind_q, kind_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  logic              done_q, done_d;
  logic              ovf_exc_q, ovf_exc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              branch_taken_q, branch_taken_d;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    kind_d         = kind_q;
    alu_op_d       = IDLE_OP;
    counter_d      = '0;
    done_d         = 1'b0;
    ovf_exc_d      = 1'b0;
    result_d       = result_q;
    branch_taken_d = branch_taken_q;

    case (state_q)
      S_IDLE: begin
        // abort outranks start so a cancelled request cannot slip in
        if (!abort_w && start) begin
          state_d  = S_ISSUE;
          last_d   = req_last;
          kind_d   = req_kind;
          alu_op_d = req_op;
        end
      end
      S_ISSUE: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (counter_q == last_q) begin
          // Closing edge of the final phase: only these logic unit values matter
          state_d = S_DONE;
          done_d  = 1'b1;
          case (kind_q)
            KIND_BRANCH: branch_taken_d = Update_UC;
            KIND_OVF: begin
              if (OVERFLOW) ovf_exc_d = 1'b1;
              else          result_d  = ALUOut;
            end
            default:     result_d = ALUOut;
          endcase
        end else begin
          alu_op_d  = alu_op_q;
          counter_d = counter_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      last_q         <= '0;
      kind_q         <= '0;
      alu_op_q       <= IDLE_OP;
      counter_q      <= '0;
      done_q         <= 1'b0;
      ovf_exc_q      <= 1'b0;
      result_q       <= '0;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      kind_q         <= kind_d;
      alu_op_q       <= alu_op_d;
      counter_q      <= counter_d;
      done_q         <= done_d;
      ovf_exc_q      <= ovf_exc_d;
      result_q       <= result_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign ALUOp        = alu_op_q;
  assign COUNTER      = counter_q;
  assign done         = done_q;
  assign ovf_exc      = ovf_exc_q;
  assign result       = result_q;
  assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level timeline model with per-cycle compare,
// directed literal pins, random traffic, mid-operation reset and (if enabled) abort.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  req_op = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_kind = '0;
  logic [3:0]  ALUOp;
  logic [1:0]  COUNTER;
  logic [31:0] ALUOut = '0;
  logic        OVERFLOW = 1'b0;
  logic        Update_UC = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, branch_taken, ovf_exc;
  logic [31:0] result;

  int checks;
  int errors;

  logic        chk_en;
  logic [3:0]  exp_op;
  logic [1:0]  exp_cnt;
  logic        exp_busy, exp_done, exp_ovf, exp_bt;
  logic [31:0] exp_result;

  alu_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .req_op       (req_op),
    .req_last     (req_last),
    .req_kind     (req_kind),
    .ALUOp        (ALUOp),
    .COUNTER      (COUNTER),
    .ALUOut       (ALUOut),
    .OVERFLOW     (OVERFLOW),
    .Update_UC    (Update_UC),
`ifdef ALU_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .result       (result),
    .branch_taken (branch_taken),
    .ovf_exc      (ovf_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ALUOp",        32'(ALUOp),        32'(exp_op));
      chk("COUNTER",      32'(COUNTER),      32'(exp_cnt));
      chk("busy",         32'(busy),         32'(exp_busy));
      chk("done",         32'(done),         32'(exp_done));
      chk("ovf_exc",      32'(ovf_exc),      32'(exp_ovf));
      chk("result",       result,            exp_result);
      chk("branch_taken", 32'(branch_taken), 32'(exp_bt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lu();
    ALUOut    = $urandom;
    OVERFLOW  = 1'($urandom_range(0, 1));
    Update_UC = 1'($urandom_range(0, 1));
  endtask

  task automatic set_idle_exp();
    exp_op   = 4'h0;
    exp_cnt  = 2'd0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic idle_tick();
    tick();
    start = 1'b0;
    rand_lu();
    set_idle_exp();
  endtask

  task automatic junk_start(input bit junk);
    if (junk) begin
      start    = 1'($urandom_range(0, 1));
      req_op   = 4'($urandom);
      req_last = 2'($urandom);
      req_kind = 2'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // Entered in an IDLE cycle; returns in the DONE cycle of this operation.
  task automatic run_op(input logic [3:0] op, input logic [1:0] last, input logic [1:0] kind,
                        input bit fixed, input logic [31:0] fout, input bit fovf, input bit fuc,
                        input bit junk);
    logic [31:0] cap_out;
    logic        cap_ovf, cap_uc;
    start    = 1'b1;
    req_op   = op;
    req_last = last;
    req_kind = kind;
    for (int k = 1; k <= int'(last) + 1; k++) begin
      tick();
      junk_start(junk);
      rand_lu();
      if (k == int'(last) + 1 && fixed) begin
        ALUOut    = fout;
        OVERFLOW  = fovf;
        Update_UC = fuc;
      end
      exp_op   = op;
      exp_cnt  = 2'(k - 1);
      exp_busy = 1'b1;
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
    end
    cap_out = ALUOut;
    cap_ovf = OVERFLOW;
    cap_uc  = Update_UC;
    tick();
    junk_start(junk);
    rand_lu();
    exp_op   = 4'h0;
    exp_cnt  = 2'd0;
    exp_busy = 1'b1;
    exp_done = 1'b1;
    exp_ovf  = 1'b0;
    case (kind)
      2'b01: exp_bt = cap_uc;
      2'b10: begin
        if (cap_ovf) exp_ovf = 1'b1;
        else         exp_result = cap_out;
      end
      default: exp_result = cap_out;
    endcase
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    exp_result = '0;
    exp_bt = 1'b0;
    set_idle_exp();
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_result_lit", result, 32'h0);
    chk("rst_busy_lit", 32'(busy), 32'h0);

    run_op(4'h1, 2'd0, 2'b00, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    chk("single_done_lit", 32'(done), 32'h1);
    chk("single_result_lit", result, 32'h5);
    idle_tick();

    run_op(4'h2, 2'd3, 2'b00, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    chk("four_phase_result_lit", result, 32'h1234_5678);
    idle_tick();

    run_op(4'h3, 2'd1, 2'b01, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("branch_taken1_lit", 32'(branch_taken), 32'h1);
    chk("branch_result_hold_lit", result, 32'h1234_5678);
    idle_tick();

    run_op(4'h3, 2'd1, 2'b01, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("branch_taken0_lit", 32'(branch_taken), 32'h0);
    idle_tick();

    run_op(4'h4, 2'd2, 2'b10, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    chk("ovf_exc_lit", 32'(ovf_exc), 32'h1);
    chk("ovf_result_hold_lit", result, 32'h1234_5678);
    idle_tick();

    run_op(4'h4, 2'd2, 2'b00, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    chk("plain_no_ovf_lit", 32'(ovf_exc), 32'h0);
    chk("plain_result_lit", result, 32'h8000_0000);
    idle_tick();

    // start pulses during ISSUE/DONE must be dropped
    run_op(4'h5, 2'd3, 2'b11, 1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b1);
    chk("kind3_result_lit", result, 32'h0000_00A5);
    idle_tick();
    repeat (2) idle_tick();

    for (int n = 0; n < 200; n++) begin
      run_op(4'($urandom), 2'($urandom), 2'($urandom), 1'b0, 32'h0, 1'b0, 1'b0,
             1'($urandom_range(0, 1)));
      idle_tick();
      repeat ($urandom_range(0, 2)) idle_tick();
    end

    // reset in cycle 2 of a 4-phase operation
    start    = 1'b1;
    req_op   = 4'h9;
    req_last = 2'd3;
    req_kind = 2'b00;
    tick();
    start = 1'b0;
    exp_op = 4'h9; exp_cnt = 2'd0; exp_busy = 1'b1; exp_done = 1'b0; exp_ovf = 1'b0;
    tick();
    exp_cnt = 2'd1;
    #1 reset = 1'b0;
    exp_result = '0;
    exp_bt = 1'b0;
    set_idle_exp();
    #1;
    chk("midrst_aluop_lit", 32'(ALUOp), 32'h0);
    chk("midrst_busy_lit", 32'(busy), 32'h0);
    chk("midrst_result_lit", result, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    repeat (6) idle_tick();

`ifdef ALU_SEQ_ABORT_EN
    run_op(4'h6, 2'd0, 2'b00, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    idle_tick();
    start    = 1'b1;
    req_op   = 4'h7;
    req_last = 2'd3;
    req_kind = 2'b00;
    tick();
    start = 1'b0;
    exp_op = 4'h7; exp_cnt = 2'd0; exp_busy = 1'b1; exp_done = 1'b0; exp_ovf = 1'b0;
    tick();
    exp_cnt = 2'd1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    set_idle_exp();
    chk("abort_result_lit", result, 32'h0000_0077);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    set_idle_exp();
    repeat (4) idle_tick();
`endif

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issuing side of the ALU operation interface in the multicycle processor: accepts a one-cycle operation request from the main control FSM, drives `ALUOp` and the `COUNTER` phase index into the logic unit for the required number of cycles, then samples `ALUOut`, `OVERFLOW` and `Update_UC`. It returns a registered result, a branch decision and an overflow exception flag with a one-cycle `done` pulse. This lets the main control FSM issue multi-phase operations (shifter load/shift, compare-and-branch) without tracking the phase counter itself.

## Interface
Parameters:
- `DATA_W`, 32, datapath width of `ALUOut`/`result`
- `OP_W`, 4, width of `ALUOp`
- `CNT_W`, 2, width of `COUNTER`; maximum phase count 2^CNT_W
- `IDLE_OP`, 4'b0000, `ALUOp` value driven while not issuing

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `start`  in  1  request strobe from main control FSM, sampled only when `busy`=0
- `req_op`  in  OP_W  ALUOp code to issue
- `req_last`  in  CNT_W  index of last phase (phases issued = req_last+1)
- `req_kind`  in  2  00 plain, 01 branch, 10 overflow-checked, 11 treated as 00
- `ALUOp`  out  OP_W  operation to logic unit (registered)
- `COUNTER`  out  CNT_W  phase index to logic unit (registered)
- `ALUOut`  in  DATA_W  logic unit result
- `OVERFLOW`  in  1  logic unit overflow
- `Update_UC`  in  1  logic unit branch condition
- `busy`  out  1  high from accepting edge until end of `done` cycle
- `done`  out  1  one-cycle completion pulse
- `result`  out  DATA_W  last committed result, held between operations
- `branch_taken`  out  1  `Update_UC` captured on last branch op, held
- `ovf_exc`  out  1  one-cycle pulse, coincident with `done`
- `abort`  in  1  only with `ALU_SEQ_ABORT_EN`

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: `ALUOp`=IDLE_OP, `COUNTER`=0, `busy`=0. `start`=1 latches `req_op`, `req_last`, `req_kind`; next state ISSUE.
- ISSUE: `ALUOp`=latched op, `COUNTER` starts at 0, increments by 1 each cycle. When `COUNTER`==latched `req_last`, the closing edge captures inputs and moves to DONE; `COUNTER` does not wrap.
- Capture: kind 00/11: `result`<=`ALUOut`. Kind 01: `branch_taken`<=`Update_UC`, `result` unchanged. Kind 10: if `OVERFLOW`=0, `result`<=`ALUOut`; if 1, `result` unchanged and `ovf_exc` asserted in DONE.
- `OVERFLOW` ignored for kinds 00/01/11; `Update_UC` ignored except kind 01.
- DONE: `done`=1, `busy`=1, `ALUOp`=IDLE_OP, `COUNTER`=0; next state IDLE unconditionally. `start` in DONE is ignored.
- `start` while `busy`=1 is dropped, not queued.

## Timing
- Reset (low, async): state IDLE, `ALUOp`=IDLE_OP, `COUNTER`=0, `busy`=0, `done`=0, `result`=0, `branch_taken`=0, `ovf_exc`=0. Reset mid-operation discards the operation; no `done`.
- `start` accepted at edge E0. ISSUE cycles 1..req_last+1 carry `COUNTER`=0..req_last. `done` high in cycle req_last+2. IDLE in cycle req_last+3, so back-to-back `start` is accepted at the edge ending the DONE cycle+1, never earlier.
- `req_last`=0: a single ISSUE cycle, `done` in cycle 2.
- Logic unit inputs must be valid before the edge ending the final ISSUE cycle. Earlier phase values are not sampled.

## Configuration
- `ALU_SEQ_ABORT_EN` defined: `abort` port present. `abort`=1 in ISSUE or DONE returns to IDLE at the next edge, drives IDLE outputs, suppresses `done`/`ovf_exc`, and leaves `result`/`branch_taken` unchanged. In IDLE, `abort` has priority over `start`.
- Not defined: no `abort` port; operations always run to `done`.

## Test plan
- `req_op`=4'h1, `req_last`=0, kind 00, `ALUOut`=32'h0000_0005 -> `ALUOp`=1 for one cycle, `done` in cycle 2, `result`=5.
- `req_last`=3, kind 00 -> `COUNTER` 0,1,2,3 in cycles 1-4, `done` cycle 5, `result`=`ALUOut` value present in cycle 4 only.
- Kind 01, `Update_UC`=1 on last phase -> `branch_taken`=1, `result` unchanged. A repeat with `Update_UC`=0 -> `branch_taken`=0.
- Kind 10, `ALUOut`=32'h8000_0000, `OVERFLOW`=1 -> `ovf_exc`=1 with `done`, `result` retains prior value. The same request with `OVERFLOW`=1 under kind 00 -> no `ovf_exc`, `result`=32'h8000_0000.
- `start` pulsed during ISSUE and DONE -> ignored, exactly one `done`. `reset` low in cycle 2 of a 4-phase op -> all outputs at reset values immediately, no `done`.
- With `ALU_SEQ_ABORT_EN`: `abort` in cycle 2 of a 4-phase op -> IDLE next cycle, no `done`, `result` unchanged.
